alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID->EX issue stage directly upstream of the ALU: captures decoded operands,
//  resolves RAW hazards by forwarding, selects A/B sources, and drives A, B, ALUOp.
//  A 2-entry skid buffer with valid/ready handshake keeps InReady a registered signal.
// PARAMETERS
//  XLEN        32  datapath width (A, B, PC, Imm, forward data)
//  REG_ADDR_W  5   register-index width; index 0 is x0 (hardwired zero)
// PORTS
//  clk         in   1           rising-edge clock
//  rst_n       in   1           asynchronous active-low reset
//  InValid     in   1           upstream entry valid
//  InReady     out  1           stage can accept; registered
//  Rs1Addr     in   REG_ADDR_W  source-1 index
//  Rs2Addr     in   REG_ADDR_W  source-2 index
//  Rs1Data     in   XLEN        register-file read data 1
//  Rs2Data     in   XLEN        register-file read data 2
//  PC          in   XLEN        instruction PC
//  Imm         in   XLEN        sign-extended immediate
//  ALUASrc     in   1           0: forwarded rs1, 1: PC
//  ALUBSrc     in   1           0: forwarded rs2, 1: Imm
//  ALUOpIn     in   4           ALU operation code, passed through unchanged
//  RdAddrIn    in   REG_ADDR_W  destination index
//  RegWrIn     in   1           destination write enable
//  ExFwdValid  in   1           EX/MEM result writes ExFwdRd
//  ExFwdRd     in   REG_ADDR_W  EX/MEM destination
//  ExFwdData   in   XLEN        EX/MEM result
//  WbFwdValid  in   1           MEM/WB result writes WbFwdRd
//  WbFwdRd     in   REG_ADDR_W  MEM/WB destination
//  WbFwdData   in   XLEN        MEM/WB result
//  Flush       in   1           kill all buffered entries (branch/jump)
//  OutValid    out  1           A/B/ALUOp/RdAddr/RegWr valid
//  OutReady    in   1           ALU side consumes this cycle
//  A           out  XLEN        ALU operand A
//  B           out  XLEN        ALU operand B
//  ALUOp       out  4           ALU operation code
//  RdAddr      out  REG_ADDR_W  destination index
//  RegWr       out  1           destination write enable
// BEHAVIOUR
//  Reset (rst_n=0, async): state EMPTY, OutValid=0, InReady=1; A, B, ALUOp, RdAddr, RegWr = 0.
//  Capture: InValid&&InReady at rising edge. Forwarding and source selection resolve at capture.
//  Forwarding per source s (rs1/rs2):
//   - ExFwdValid && ExFwdRd==s && s!=0 -> ExFwdData;
//   - else WbFwdValid && WbFwdRd==s && s!=0 -> WbFwdData;
//   - else RsData. EX beats WB.
//   - s==0 always yields 0, regardless of Rs*Data.
//  A = ALUASrc ? PC : fwd(rs1); B = ALUBSrc ? Imm : fwd(rs2). No width change; XLEN bits.
//  Latency: 1 cycle from capture to OutValid when the stage is EMPTY.
//  States (main reg M drives outputs, skid reg S):
//   - EMPTY: capture -> ONE (into M).
//   - ONE: capture&&!OutReady -> FULL (into S).
//   - ONE: !capture&&OutReady -> EMPTY.
//   - ONE: capture&&OutReady -> ONE (M replaced).
//   - FULL: OutReady -> ONE (S moves to M); no capture possible.
//  InReady = (next state != FULL), registered; a FULL stage deasserts InReady.
//  Handshake: outputs hold stable while OutValid&&!OutReady; no entry lost or duplicated.
//  Flush (sync): next state EMPTY, OutValid=0, InReady=1; same-cycle capture dropped.
//   - Flush beats capture and OutReady.
//   - Data regs keep old values; only valid bits clear.
//  rst_n low mid-operation: immediate return to reset values, all entries discarded.
// TESTING
//  1 Reset, then capture rs1=3 (Rs1Data=5), rs2=4 (Rs2Data=7), ALUOpIn=0000, OutReady=1 -> next cycle OutValid=1, A=5, B=7, ALUOp=0000.
//  2 Rs1Addr=3, ExFwd(rd=3, data=0xAA), WbFwd(rd=3, data=0xBB) -> A=0xAA; EX off -> A=0xBB; Rs1Addr=0, ExFwd(rd=0, data=0xAA) -> A=0.
//  3 ALUASrc=1, PC=0x100, ALUBSrc=1, Imm=0xFFFFFFFC -> A=0x100, B=0xFFFFFFFC.
//  4 OutReady=0, issue 3 back-to-back -> 2 captured, InReady=0 after 2nd; 3rd held. Release OutReady -> order 1, 2, 3; outputs stable while stalled.
//  5 FULL, assert Flush with InValid=1 -> next cycle OutValid=0, InReady=1, nothing emitted.
//  6 rst_n=0 in FULL state, asynchronous to clk -> OutValid=0, A=B=0, InReady=1 immediately.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: forwards operands, selects ALU sources and buffers up to
// two decoded entries behind a valid/ready handshake with a registered InReady.
module alu_issue_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [REG_ADDR_W-1:0] Rs1Addr,
    input  logic [REG_ADDR_W-1:0] Rs2Addr,
    input  logic [XLEN-1:0]       Rs1Data,
    input  logic [XLEN-1:0]       Rs2Data,
    input  logic [XLEN-1:0]       PC,
    input  logic [XLEN-1:0]       Imm,
    input  logic                  ALUASrc,
    input  logic                  ALUBSrc,
    input  logic [3:0]            ALUOpIn,
    input  logic [REG_ADDR_W-1:0] RdAddrIn,
    input  logic                  RegWrIn,
    input  logic                  ExFwdValid,
    input  logic [REG_ADDR_W-1:0] ExFwdRd,
    input  logic [XLEN-1:0]       ExFwdData,
    input  logic                  WbFwdValid,
    input  logic [REG_ADDR_W-1:0] WbFwdRd,
    input  logic [XLEN-1:0]       WbFwdData,
    input  logic                  Flush,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [XLEN-1:0]       A,
    output logic [XLEN-1:0]       B,
    output logic [3:0]            ALUOp,
    output logic [REG_ADDR_W-1:0] RdAddr,
    output logic                  RegWr
);

    typedef struct packed {
        logic [XLEN-1:0]       a;
        logic [XLEN-1:0]       b;
        logic [3:0]            alu_op;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  reg_wr;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, next_state;
    entry_t main_q, skid_q, in_entry;
    logic   capture, load_main, load_skid, skid_to_main;

    // x0 always reads zero; the newer EX/MEM result wins over MEM/WB.
    function automatic logic [XLEN-1:0] fwd(
        input logic [REG_ADDR_W-1:0] src,
        input logic [XLEN-1:0]       rf_data,
        input logic                  ex_valid,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic [XLEN-1:0]       ex_data,
        input logic                  wb_valid,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [XLEN-1:0]       wb_data
    );
        if (src == '0)                       return '0;
        else if (ex_valid && (ex_rd == src)) return ex_data;
        else if (wb_valid && (wb_rd == src)) return wb_data;
        else                                 return rf_data;
    endfunction

    assign capture = InValid && InReady;

    always_comb begin
        in_entry.a       = ALUASrc ? PC : fwd(Rs1Addr, Rs1Data, ExFwdValid, ExFwdRd, ExFwdData,
                                             WbFwdValid, WbFwdRd, WbFwdData);
        in_entry.b       = ALUBSrc ? Imm : fwd(Rs2Addr, Rs2Data, ExFwdValid, ExFwdRd, ExFwdData,
                                              WbFwdValid, WbFwdRd, WbFwdData);
        in_entry.alu_op  = ALUOpIn;
        in_entry.rd_addr = RdAddrIn;
        in_entry.reg_wr  = RegWrIn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state   <= EMPTY;
            InReady <= 1'b1;
        end else begin
            state   <= next_state;
            InReady <= (next_state != FULL);
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves next_state
        // unassigned, which would infer a latch.
        next_state = state;
        unique case (state)
            EMPTY: if (capture) next_state = ONE;
            ONE: begin
                if (capture && !OutReady)      next_state = FULL;
                else if (!capture && OutReady) next_state = EMPTY;
            end
            FULL:    if (OutReady) next_state = ONE;
            default: next_state = EMPTY;
        endcase
        if (Flush) next_state = EMPTY;
    end

    always_comb begin
        OutValid     = (state != EMPTY);
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (!Flush) begin
            load_main    = capture && ((state == EMPTY) || (state == ONE && OutReady));
            load_skid    = capture && (state == ONE) && !OutReady;
            skid_to_main = (state == FULL) && OutReady;
        end
    end

    // Flush only clears validity through the state; payload registers keep their contents.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: payload registers are reset because their contents drive A/B/ALUOp
        // directly and must read zero after reset.
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)         main_q <= in_entry;
            else if (skid_to_main) main_q <= skid_q;
            if (load_skid)         skid_q <= in_entry;
        end
    end

    assign A      = main_q.a;
    assign B      = main_q.b;
    assign ALUOp  = main_q.alu_op;
    assign RdAddr = main_q.rd_addr;
    assign RegWr  = main_q.reg_wr;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a randomized
// run against a queue-based model of the two-entry buffer.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        InValid, InReady;
    logic [4:0]  Rs1Addr, Rs2Addr, RdAddrIn, ExFwdRd, WbFwdRd, RdAddr;
    logic [31:0] Rs1Data, Rs2Data, PC, Imm, ExFwdData, WbFwdData, A, B;
    logic        ALUASrc, ALUBSrc, RegWrIn, ExFwdValid, WbFwdValid, Flush;
    logic        OutValid, OutReady, RegWr;
    logic [3:0]  ALUOpIn, ALUOp;
    exp_t        obs;

    int checks = 0;
    int passes = 0;

    alu_issue_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
        .Rs1Addr(Rs1Addr), .Rs2Addr(Rs2Addr), .Rs1Data(Rs1Data), .Rs2Data(Rs2Data),
        .PC(PC), .Imm(Imm), .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc), .ALUOpIn(ALUOpIn),
        .RdAddrIn(RdAddrIn), .RegWrIn(RegWrIn),
        .ExFwdValid(ExFwdValid), .ExFwdRd(ExFwdRd), .ExFwdData(ExFwdData),
        .WbFwdValid(WbFwdValid), .WbFwdRd(WbFwdRd), .WbFwdData(WbFwdData),
        .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
        .A(A), .B(B), .ALUOp(ALUOp), .RdAddr(RdAddr), .RegWr(RegWr)
    );

    always #5 clk = ~clk;

    assign obs = {A, B, ALUOp, RdAddr, RegWr};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        InValid = 0; Rs1Addr = 0; Rs2Addr = 0; Rs1Data = 0; Rs2Data = 0;
        PC = 0; Imm = 0; ALUASrc = 0; ALUBSrc = 0; ALUOpIn = 0; RdAddrIn = 0;
        RegWrIn = 0; ExFwdValid = 0; ExFwdRd = 0; ExFwdData = 0;
        WbFwdValid = 0; WbFwdRd = 0; WbFwdData = 0; Flush = 0; OutReady = 0;
    endtask

    // Plain register-read entry: rs1 -> A, rs2 -> B, no forwarding.
    task automatic drive_plain(input logic [31:0] d1, input logic [31:0] d2,
                               input logic [3:0] op, input logic [4:0] rd);
        InValid = 1; Rs1Addr = 5'd5; Rs2Addr = 5'd6; Rs1Data = d1; Rs2Data = d2;
        ALUASrc = 0; ALUBSrc = 0; ALUOpIn = op; RdAddrIn = rd; RegWrIn = 1;
        ExFwdValid = 0; WbFwdValid = 0;
    endtask

    // Reference operand value: x0 reads 0, then youngest in-flight producer, then RF.
    function automatic logic [31:0] ref_src(input logic [4:0] s, input logic [31:0] rf);
        logic [31:0] v;
        v = rf;
        if (WbFwdValid && WbFwdRd == s) v = WbFwdData;
        if (ExFwdValid && ExFwdRd == s) v = ExFwdData;
        return (s == 5'd0) ? 32'd0 : v;
    endfunction

    task automatic test_reset();
        rst_n = 0;
        idle();
        #12;
        checks++;
        if ({OutValid, InReady} !== 2'b01) $display("FAIL reset_hs: got valid/ready=%b expected 01", {OutValid, InReady});
        else passes++;
        checks++;
        if (obs !== '0) $display("FAIL reset_data: got %h expected 0", obs);
        else passes++;
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_basic();
        OutReady = 1;
        InValid = 1; Rs1Addr = 5'd3; Rs1Data = 32'd5; Rs2Addr = 5'd4; Rs2Data = 32'd7;
        ALUOpIn = 4'b0000; RdAddrIn = 5'd9; RegWrIn = 1;
        tick();
        InValid = 0;
        checks++;
        if ({OutValid, InReady} !== 2'b11) $display("FAIL basic_hs: got %b expected 11", {OutValid, InReady});
        else passes++;
        checks++;
        if (obs !== exp_t'{32'd5, 32'd7, 4'd0, 5'd9, 1'b1}) $display("FAIL basic_data: got %h expected a=5 b=7", obs);
        else passes++;
        tick();
        checks++;
        if (OutValid !== 1'b0) $display("FAIL basic_drain: got OutValid=%b expected 0", OutValid);
        else passes++;
    endtask

    task automatic test_forwarding();
        OutReady = 1;
        InValid = 1; Rs1Addr = 5'd3; Rs1Data = 32'h11; Rs2Addr = 5'd3; Rs2Data = 32'h22;
        ExFwdValid = 1; ExFwdRd = 5'd3; ExFwdData = 32'hAA;
        WbFwdValid = 1; WbFwdRd = 5'd3; WbFwdData = 32'hBB;
        tick();
        checks++;
        if (A !== 32'hAA || B !== 32'hAA) $display("FAIL fwd_ex: got A=%h B=%h expected aa aa", A, B);
        else passes++;
        ExFwdValid = 0;
        tick();
        checks++;
        if (A !== 32'hBB || B !== 32'hBB) $display("FAIL fwd_wb: got A=%h B=%h expected bb bb", A, B);
        else passes++;
        Rs1Addr = 5'd0; Rs1Data = 32'h1234; ExFwdValid = 1; ExFwdRd = 5'd0; WbFwdRd = 5'd0;
        Rs2Addr = 5'd7; Rs2Data = 32'h77;
        tick();
        checks++;
        if (A !== 32'h0 || B !== 32'h77) $display("FAIL fwd_x0: got A=%h B=%h expected 0 77", A, B);
        else passes++;
        idle();
        OutReady = 1;
        tick();
    endtask

    task automatic test_src_select();
        OutReady = 1;
        InValid = 1; Rs1Addr = 5'd3; Rs2Addr = 5'd3; ExFwdValid = 1; ExFwdRd = 5'd3; ExFwdData = 32'hAA;
        ALUASrc = 1; PC = 32'h100; ALUBSrc = 1; Imm = 32'hFFFF_FFFC; ALUOpIn = 4'b1010;
        tick();
        checks++;
        if (A !== 32'h100 || B !== 32'hFFFF_FFFC || ALUOp !== 4'b1010)
            $display("FAIL src_sel: got A=%h B=%h op=%h expected 100 fffffffc a", A, B, ALUOp);
        else passes++;
        idle();
        OutReady = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        OutReady = 0;
        drive_plain(32'h11, 32'h1, 4'd1, 5'd1);
        tick();
        checks++;
        if ({OutValid, InReady} !== 2'b11 || A !== 32'h11) $display("FAIL b2b_first: got v/r=%b A=%h expected 11 11", {OutValid, InReady}, A);
        else passes++;
        drive_plain(32'h22, 32'h2, 4'd2, 5'd2);
        tick();
        checks++;
        if (InReady !== 1'b0 || A !== 32'h11) $display("FAIL b2b_full: got ready=%b A=%h expected 0 11", InReady, A);
        else passes++;
        drive_plain(32'h33, 32'h3, 4'd3, 5'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({OutValid, InReady} !== 2'b10 || obs !== exp_t'{32'h11, 32'h1, 4'd1, 5'd1, 1'b1})
                $display("FAIL b2b_stall: got v/r=%b out=%h expected 10 held entry 1", {OutValid, InReady}, obs);
            else passes++;
        end
        OutReady = 1;
        tick();
        checks++;
        if ({OutValid, InReady} !== 2'b11 || obs !== exp_t'{32'h22, 32'h2, 4'd2, 5'd2, 1'b1})
            $display("FAIL b2b_second: got v/r=%b out=%h expected 11 entry 2", {OutValid, InReady}, obs);
        else passes++;
        tick();
        InValid = 0;
        checks++;
        if (OutValid !== 1'b1 || obs !== exp_t'{32'h33, 32'h3, 4'd3, 5'd3, 1'b1})
            $display("FAIL b2b_third: got v=%b out=%h expected entry 3", OutValid, obs);
        else passes++;
        tick();
        checks++;
        if (OutValid !== 1'b0) $display("FAIL b2b_drain: got OutValid=%b expected 0", OutValid);
        else passes++;
    endtask

    task automatic test_flush();
        OutReady = 0;
        drive_plain(32'h44, 32'h4, 4'd4, 5'd4);
        tick();
        drive_plain(32'h55, 32'h5, 4'd5, 5'd5);
        Flush = 1;
        tick();
        Flush = 0;
        checks++;
        if ({OutValid, InReady} !== 2'b01 || A !== 32'h44)
            $display("FAIL flush_one: got v/r=%b A=%h expected 01 44", {OutValid, InReady}, A);
        else passes++;
        InValid = 0;
        tick();
        drive_plain(32'h66, 32'h6, 4'd6, 5'd6);
        tick();
        drive_plain(32'h77, 32'h7, 4'd7, 5'd7);
        tick();
        Flush = 1;
        tick();
        Flush = 0;
        InValid = 0;
        checks++;
        if ({OutValid, InReady} !== 2'b01) $display("FAIL flush_full: got v/r=%b expected 01", {OutValid, InReady});
        else passes++;
        OutReady = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (OutValid !== 1'b0) $display("FAIL flush_nothing: got OutValid=%b expected 0", OutValid);
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        OutReady = 0;
        drive_plain(32'h88, 32'h8, 4'd8, 5'd8);
        tick();
        drive_plain(32'h99, 32'h9, 4'd9, 5'd9);
        tick();
        InValid = 0;
        #2 rst_n = 0;
        #1;
        checks++;
        if ({OutValid, InReady} !== 2'b01 || A !== 32'h0 || B !== 32'h0)
            $display("FAIL async_rst: got v/r=%b A=%h B=%h expected 01 0 0", {OutValid, InReady}, A, B);
        else passes++;
        @(negedge clk);
        rst_n = 1;
        OutReady = 1;
        tick();
        checks++;
        if (OutValid !== 1'b0) $display("FAIL async_rst_drain: got OutValid=%b expected 0", OutValid);
        else passes++;
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t cand;
        logic model_ready;
        logic cap;
        idle();
        #2 rst_n = 0;
        #2 rst_n = 1;
        model_ready = 1;
        for (int n = 0; n < 3000; n++) begin
            InValid    = ($urandom_range(0, 3) != 0);
            OutReady   = ($urandom_range(0, 2) != 0);
            Flush      = ($urandom_range(0, 15) == 0);
            Rs1Addr    = 5'($urandom_range(0, 3));
            Rs2Addr    = 5'($urandom_range(0, 3));
            Rs1Data    = $urandom;
            Rs2Data    = $urandom;
            PC         = $urandom;
            Imm        = $urandom;
            ALUASrc    = ($urandom_range(0, 3) == 0);
            ALUBSrc    = ($urandom_range(0, 3) == 0);
            ALUOpIn    = 4'($urandom_range(0, 15));
            RdAddrIn   = 5'($urandom_range(0, 31));
            RegWrIn    = 1'($urandom_range(0, 1));
            ExFwdValid = 1'($urandom_range(0, 1));
            ExFwdRd    = 5'($urandom_range(0, 3));
            ExFwdData  = $urandom;
            WbFwdValid = 1'($urandom_range(0, 1));
            WbFwdRd    = 5'($urandom_range(0, 3));
            WbFwdData  = $urandom;
            cand.a  = ALUASrc ? PC : ref_src(Rs1Addr, Rs1Data);
            cand.b  = ALUBSrc ? Imm : ref_src(Rs2Addr, Rs2Data);
            cand.op = ALUOpIn;
            cand.rd = RdAddrIn;
            cand.wr = RegWrIn;
            cap = InValid && model_ready;
            tick();
            if (Flush) begin
                q.delete();
            end else begin
                if (OutReady && q.size() > 0) void'(q.pop_front());
                if (cap) q.push_back(cand);
            end
            model_ready = (q.size() < 2);
            checks++;
            if (OutValid !== (q.size() > 0) || InReady !== model_ready)
                $display("FAIL rand_hs[%0d]: got v/r=%b%b expected %b%b", n, OutValid, InReady, q.size() > 0, model_ready);
            else passes++;
            if (q.size() > 0) begin
                checks++;
                if (obs !== q[0]) $display("FAIL rand_data[%0d]: got %h expected %h", n, obs, q[0]);
                else passes++;
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forwarding();
        test_src_select();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
